// File: rtl/cache_way_array.sv
// Set-associative tag/data storage with valid, round-robin and optional dirty state.
// Optional feature macro: CACHE_DIRTY_EN (per-line dirty bits, reported on the victim).

module sp_ram_wrap #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wmask,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
  end

  // Read-before-write: a write cycle returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end
endmodule

module cache_way_array #(
  parameter int WAY_COUNT  = 2,
  parameter int SET_COUNT  = 64,
  parameter int LINE_WORDS = 4,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int BYTES  = WORD_WIDTH / 8,
  localparam int BYTE_W = $clog2(BYTES),
  localparam int WIDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int OFS_W  = $clog2(LINE_WORDS) + BYTE_W,
  localparam int SET_W  = $clog2(SET_COUNT),
  localparam int TAG_W  = ADDR_WIDTH - SET_W - OFS_W,
  localparam int WAY_W  = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1,
  localparam int LINE_W = LINE_WORDS * WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WAY_W-1:0]      req_way_i,
  input  logic [LINE_W-1:0]     req_line_i,
  input  logic [WORD_WIDTH-1:0] req_wdata_i,
  input  logic [BYTES-1:0]      req_be_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o,
  output logic                  resp_valid_o,
  output logic                  resp_hit_o,
  output logic [WAY_W-1:0]      resp_way_o,
  output logic [LINE_W-1:0]     resp_line_o,
  output logic [TAG_W-1:0]      resp_victim_tag_o,
  output logic                  resp_victim_dirty_o
);
  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;
  localparam int DROW_W = WAY_COUNT * WORD_WIDTH;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                               state;
  logic [SET_W-1:0]                     flush_cnt;
  logic [SET_COUNT-1:0][WAY_COUNT-1:0]  valid_q;
  logic [SET_COUNT-1:0][WAY_W-1:0]      rr_q;
  logic [TAG_W-1:0]                     snap_tag;
  logic [WAY_COUNT-1:0]                 snap_valid;
  logic [WAY_W-1:0]                     snap_rr;
`ifdef CACHE_DIRTY_EN
  logic [SET_COUNT-1:0][WAY_COUNT-1:0]  dirty_q;
  logic [WAY_COUNT-1:0]                 snap_dirty;
`endif

  logic             accept;
  logic [SET_W-1:0] req_set;
  logic [TAG_W-1:0] req_tag;
  logic [WIDX_W-1:0] word_idx;
  logic [WAY_W-1:0] rr_next;

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign busy_o      = (state == FLUSH);
  assign accept      = req_valid_i && req_ready_o;
  assign req_set     = req_addr_i[OFS_W +: SET_W];
  assign req_tag     = req_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign rr_next     = (WAY_COUNT == 1) ? '0 : WAY_W'(req_way_i + WAY_W'(1));

  generate
    if (LINE_WORDS > 1) begin : g_widx
      assign word_idx = req_addr_i[BYTE_W +: WIDX_W];
    end else begin : g_no_widx
      assign word_idx = '0;
    end
    if (BYTE_W > 0) begin : g_byte_ofs
      logic unused_byte_ofs;
      assign unused_byte_ofs = ^req_addr_i[BYTE_W-1:0];
    end
  endgenerate

  logic [TAG_W-1:0] tag_rd [WAY_COUNT];

  genvar gw, gk;
  generate
    for (gw = 0; gw < WAY_COUNT; gw++) begin : g_tag
      sp_ram_wrap #(.DATA_WIDTH(TAG_W), .ADDR_WIDTH(SET_W)) u_tag_ram (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .we    (accept && (req_op_i == OP_FILL) && (req_way_i == WAY_W'(gw))),
        .addr  (req_set),
        .wdata (req_tag),
        .wmask ({TAG_W{1'b1}}),
        .rdata (tag_rd[gw])
      );
    end
  endgenerate

  // Each word RAM holds that word for every way side by side; a bit mask picks the way/bytes.
  logic [DROW_W-1:0] data_rd    [LINE_WORDS];
  logic [DROW_W-1:0] data_wdata [LINE_WORDS];
  logic [DROW_W-1:0] data_wmask [LINE_WORDS];
  logic              data_we;

  assign data_we = accept && ((req_op_i == OP_FILL) || (req_op_i == OP_WRITE));

  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      data_wmask[k] = '0;
      data_wdata[k] = (req_op_i == OP_FILL) ? {WAY_COUNT{req_line_i[k*WORD_WIDTH +: WORD_WIDTH]}}
                                            : {WAY_COUNT{req_wdata_i}};
      for (int w = 0; w < WAY_COUNT; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          if ((req_way_i == WAY_W'(w)) &&
              ((req_op_i == OP_FILL) ||
               ((req_op_i == OP_WRITE) && (word_idx == WIDX_W'(k)) && req_be_i[b])))
            data_wmask[k][w*WORD_WIDTH + b*8 +: 8] = 8'hFF;
        end
      end
    end
  end

  generate
    for (gk = 0; gk < LINE_WORDS; gk++) begin : g_data
      sp_ram_wrap #(.DATA_WIDTH(DROW_W), .ADDR_WIDTH(SET_W)) u_data_ram (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .we    (data_we),
        .addr  (req_set),
        .wdata (data_wdata[gk]),
        .wmask (data_wmask[gk]),
        .rdata (data_rd[gk])
      );
    end
  endgenerate

  // Control state, flop-based line state and the per-request snapshot used by the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      flush_done_o <= 1'b0;
      resp_valid_o <= 1'b0;
      valid_q      <= '0;
      rr_q         <= '0;
      snap_tag     <= '0;
      snap_valid   <= '0;
      snap_rr      <= '0;
`ifdef CACHE_DIRTY_EN
      dirty_q      <= '0;
      snap_dirty   <= '0;
`endif
    end else begin
      resp_valid_o <= accept;
      flush_done_o <= 1'b0;
      if (accept) begin
        snap_tag   <= req_tag;
        snap_valid <= valid_q[req_set];
        snap_rr    <= rr_q[req_set];
`ifdef CACHE_DIRTY_EN
        snap_dirty <= dirty_q[req_set];
`endif
        case (req_op_i)
          OP_FILL: begin
            valid_q[req_set][req_way_i] <= 1'b1;
            rr_q[req_set]               <= rr_next;
`ifdef CACHE_DIRTY_EN
            dirty_q[req_set][req_way_i] <= 1'b0;
`endif
          end
          OP_INVAL: begin
            valid_q[req_set][req_way_i] <= 1'b0;
`ifdef CACHE_DIRTY_EN
            dirty_q[req_set][req_way_i] <= 1'b0;
`endif
          end
`ifdef CACHE_DIRTY_EN
          OP_WRITE: dirty_q[req_set][req_way_i] <= 1'b1;
`endif
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (flush_i) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          valid_q[flush_cnt] <= '0;
`ifdef CACHE_DIRTY_EN
          dirty_q[flush_cnt] <= '0;
`endif
          flush_cnt <= flush_cnt + SET_W'(1);
          if (flush_cnt == SET_W'(SET_COUNT - 1)) begin
            state        <= IDLE;
            flush_done_o <= 1'b1;
            rr_q         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;

  // Descending scans so the lowest-index match / invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = snap_rr;
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (snap_valid[w] && (tag_rd[w] == snap_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!snap_valid[w]) victim = WAY_W'(w);
    end
  end

  assign resp_hit_o        = hit;
  assign resp_way_o        = hit ? hit_way : victim;
  assign resp_victim_tag_o = tag_rd[victim];

  always_comb begin
    resp_line_o = '0;
    for (int k = 0; k < LINE_WORDS; k++)
      resp_line_o[k*WORD_WIDTH +: WORD_WIDTH] = data_rd[k][resp_way_o*WORD_WIDTH +: WORD_WIDTH];
  end

`ifdef CACHE_DIRTY_EN
  assign resp_victim_dirty_o = snap_valid[victim] && snap_dirty[victim];
`else
  assign resp_victim_dirty_o = 1'b0;
`endif

endmodule

// File: tb/tb_cache_way_array.sv
// Directed, table-driven bench for cache_way_array (default parameters),
// with hand-written flush and reset-during-flush sequences.

module tb_cache_way_array;
  localparam logic [1:0] LOOKUP = 2'b00;
  localparam logic [1:0] FILL   = 2'b01;
  localparam logic [1:0] WRITE  = 2'b10;
  localparam logic [1:0] INVAL  = 2'b11;
`ifdef CACHE_DIRTY_EN
  localparam logic DIRTY = 1'b1;
`else
  localparam logic DIRTY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid_i, req_ready_o;
  logic [1:0]   req_op_i;
  logic [31:0]  req_addr_i;
  logic [0:0]   req_way_i;
  logic [127:0] req_line_i;
  logic [31:0]  req_wdata_i;
  logic [3:0]   req_be_i;
  logic         flush_i, busy_o, flush_done_o;
  logic         resp_valid_o, resp_hit_o;
  logic [0:0]   resp_way_o;
  logic [127:0] resp_line_o;
  logic [21:0]  resp_victim_tag_o;
  logic         resp_victim_dirty_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_way_array dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_op_i            (req_op_i),
    .req_addr_i          (req_addr_i),
    .req_way_i           (req_way_i),
    .req_line_i          (req_line_i),
    .req_wdata_i         (req_wdata_i),
    .req_be_i            (req_be_i),
    .flush_i             (flush_i),
    .busy_o              (busy_o),
    .flush_done_o        (flush_done_o),
    .resp_valid_o        (resp_valid_o),
    .resp_hit_o          (resp_hit_o),
    .resp_way_o          (resp_way_o),
    .resp_line_o         (resp_line_o),
    .resp_victim_tag_o   (resp_victim_tag_o),
    .resp_victim_dirty_o (resp_victim_dirty_o)
  );

  typedef struct {
    logic [1:0]   op;
    logic [31:0]  addr;
    logic         way;
    logic [127:0] line;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic         hit;
    logic         rway;
    logic         chk_line;
    logic [127:0] eline;
    logic         chk_tag;
    logic [21:0]  etag;
    logic         edirty;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [31:0] addr, logic way, logic [127:0] line,
                              logic [31:0] wdata, logic [3:0] be, logic hit, logic rway,
                              logic chk_line, logic [127:0] eline, logic chk_tag,
                              logic [21:0] etag, logic edirty);
    vec_t v;
    v.op = op; v.addr = addr; v.way = way; v.line = line; v.wdata = wdata; v.be = be;
    v.hit = hit; v.rway = rway; v.chk_line = chk_line; v.eline = eline;
    v.chk_tag = chk_tag; v.etag = etag; v.edirty = edirty;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
    end
  endtask

  // One request per cycle; response checked #1 after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = v.op;
    req_addr_i  = v.addr;
    req_way_i   = v.way;
    req_line_i  = v.line;
    req_wdata_i = v.wdata;
    req_be_i    = v.be;
    #1 checkOutput("req_ready", req_ready_o, 1);
    @(posedge clk);
    #1;
    checkOutput("resp_valid", resp_valid_o, 1);
    checkOutput("resp_hit", resp_hit_o, v.hit);
    checkOutput("resp_way", resp_way_o, v.rway);
    checkOutput("victim_dirty", resp_victim_dirty_o, v.edirty);
    if (v.chk_line) checkOutput("resp_line", resp_line_o, v.eline);
    if (v.chk_tag) checkOutput("victim_tag", resp_victim_tag_o, v.etag);
  endtask

  localparam logic [31:0]  A   = 32'h1234_5670;
  localparam logic [31:0]  B   = 32'h2234_5670;
  localparam logic [31:0]  C   = 32'h3234_5670;
  localparam logic [21:0]  TA  = 22'h48D15;
  localparam logic [127:0] L1  = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] LW  = 128'h00000004_00000003_0000CCDD_00000001;
  localparam logic [127:0] LB  = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] L7A = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] L7B = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] L7C = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

  vec_t vecs[15];

  initial begin
    int busy_cnt, done_cnt;
    logic ready_at_done;

    vecs[0]  = mk(LOOKUP, 32'h100,  0, '0, '0, '0, 0, 0, 0, '0,  0, '0, 0);
    vecs[1]  = mk(FILL,   A,        1, L1, '0, '0, 0, 0, 0, '0,  0, '0, 0);
    vecs[2]  = mk(LOOKUP, A,        0, '0, '0, '0, 1, 1, 1, L1,  0, '0, 0);
    vecs[3]  = mk(WRITE,  A + 4,    1, '0, 32'hAABBCCDD, 4'b0011, 1, 1, 1, L1, 0, '0, 0);
    vecs[4]  = mk(LOOKUP, A,        0, '0, '0, '0, 1, 1, 1, LW,  0, '0, 0);
    vecs[5]  = mk(FILL,   B,        0, LB, '0, '0, 0, 0, 0, '0,  0, '0, 0);
    vecs[6]  = mk(LOOKUP, C,        0, '0, '0, '0, 0, 1, 1, LW,  1, TA, DIRTY);
    vecs[7]  = mk(INVAL,  A,        1, '0, '0, '0, 1, 1, 1, LW,  1, TA, DIRTY);
    vecs[8]  = mk(LOOKUP, A,        0, '0, '0, '0, 0, 1, 1, LW,  1, TA, 0);
    vecs[9]  = mk(LOOKUP, B,        0, '0, '0, '0, 1, 0, 1, LB,  1, TA, 0);
    vecs[10] = mk(FILL,   32'h470,  0, L7A, '0, '0, 0, 0, 0, '0, 0, '0, 0);
    vecs[11] = mk(FILL,   32'h870,  1, L7B, '0, '0, 0, 1, 0, '0, 0, '0, 0);
    vecs[12] = mk(LOOKUP, 32'hC70,  0, '0, '0, '0, 0, 0, 1, L7A, 1, 22'd1, 0);
    vecs[13] = mk(FILL,   32'h470,  0, L7C, '0, '0, 1, 0, 1, L7A, 1, 22'd1, 0);
    vecs[14] = mk(LOOKUP, 32'hC70,  0, '0, '0, '0, 0, 1, 1, L7B, 1, 22'd2, 0);

    reset = 1'b1; req_valid_i = 1'b0; req_op_i = LOOKUP; req_addr_i = '0; req_way_i = '0;
    req_line_i = '0; req_wdata_i = '0; req_be_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_resp_valid", resp_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", flush_done_o, 0);
    checkOutput("rst_ready", req_ready_o, 1);
    checkOutput("rst_hit", resp_hit_o, 0);
    checkOutput("rst_line", resp_line_o, 0);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    @(negedge clk);
    req_valid_i = 1'b0;
    @(posedge clk);
    #1 checkOutput("resp_single_pulse", resp_valid_o, 0);

    // Flush wins over a simultaneous request.
    @(negedge clk);
    flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = LOOKUP; req_addr_i = B;
    #1 checkOutput("flush_ready_low", req_ready_o, 0);
    @(posedge clk);
    #1 checkOutput("flush_no_resp", resp_valid_o, 0);
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 1'b0;
    busy_cnt = 0; done_cnt = 0; ready_at_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy_o) busy_cnt++;
      if (flush_done_o) begin
        done_cnt++;
        ready_at_done = req_ready_o;
      end
      @(negedge clk);
    end
    checkOutput("flush_busy_cycles", busy_cnt, 64);
    checkOutput("flush_done_pulses", done_cnt, 1);
    checkOutput("flush_ready_at_done", ready_at_done, 1);
    applyStimulus(mk(LOOKUP, B,      0, '0, '0, '0, 0, 0, 0, '0, 0, '0, 0));
    applyStimulus(mk(LOOKUP, 32'h870, 0, '0, '0, '0, 0, 0, 1, L7C, 1, 22'd1, 0));

    // Reset in the middle of a flush.
    applyStimulus(mk(FILL,   B, 0, LB, '0, '0, 0, 0, 0, '0, 0, '0, 0));
    applyStimulus(mk(LOOKUP, B, 0, '0, '0, '0, 1, 0, 1, LB, 0, '0, 0));
    @(negedge clk);
    req_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("midflush_busy", busy_o, 1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midflush_rst_busy", busy_o, 0);
    checkOutput("midflush_rst_done", flush_done_o, 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (flush_done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      @(negedge clk);
    end
    checkOutput("aborted_no_done", done_cnt, 0);
    checkOutput("aborted_no_busy", busy_cnt, 0);
    applyStimulus(mk(LOOKUP, B,       0, '0, '0, '0, 0, 0, 0, '0, 0, '0, 0));
    applyStimulus(mk(LOOKUP, 32'h470, 0, '0, '0, '0, 0, 0, 0, '0, 0, '0, 0));

    @(negedge clk);
    req_valid_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_way_array.md
# cache_way_array

Parametrised set-associative storage array for the PULPino instruction/data caches. It holds tags, per-line valid bits, optional dirty bits, per-set round-robin replacement state and line data. It serves single-cycle-issue lookup, fill, word-write and invalidate requests, and runs a multi-cycle invalidate-all (flush) sequence. It sits between the cache controller FSM and the `sp_ram_wrap` macros, with one tag RAM per way and one data RAM per line word.

## Interface
Parameters:
- `WAY_COUNT`, 2 — ways per set; power of two, ≥1.
- `SET_COUNT`, 64 — sets; power of two, ≥2.
- `LINE_WORDS`, 4 — words per line; power of two.
- `WORD_WIDTH`, 32 — data word width; multiple of 8.
- `ADDR_WIDTH`, 32 — byte address width.
- Derived values:
  - `OFS_W` = log2(LINE_WORDS) + log2(WORD_WIDTH/8)
  - `SET_W` = log2(SET_COUNT)
  - `TAG_W` = ADDR_WIDTH − SET_W − OFS_W
  - `WAY_W` = max(1, log2(WAY_COUNT))

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high.
- `req_valid_i` in 1 — request present.
- `req_ready_o` out 1 — request accepted when high together with `req_valid_i`.
- `req_op_i` in 2 — 00 LOOKUP, 01 FILL, 10 WRITE, 11 INVAL.
- `req_addr_i` in ADDR_WIDTH — byte address; set, tag and word index are taken from it.
- `req_way_i` in WAY_W — target way for FILL, WRITE and INVAL.
- `req_line_i` in LINE_WORDS·WORD_WIDTH — fill data; word 0 sits in the LSBs.
- `req_wdata_i` in WORD_WIDTH — WRITE data.
- `req_be_i` in WORD_WIDTH/8 — WRITE byte enables.
- `flush_i` in 1 — start invalidate-all (level-sampled).
- `busy_o` out 1 — flush in progress.
- `flush_done_o` out 1 — one-cycle pulse at the end of a flush.
- `resp_valid_o` out 1 — response for the request accepted in the previous cycle.
- `resp_hit_o` out 1 — LOOKUP hit.
- `resp_way_o` out WAY_W — hit way on a hit, victim way on a miss.
- `resp_line_o` out LINE_WORDS·WORD_WIDTH — data of `resp_way_o`.
- `resp_victim_tag_o` out TAG_W — stored tag of the victim way.
- `resp_victim_dirty_o` out 1 — victim is both valid and dirty.

## Operation
- **State machine:** IDLE, FLUSH.
- **Ready rule:** `req_ready_o` = (state == IDLE) && !`flush_i`. Flush wins over a simultaneous request; that request is not accepted.
- **LOOKUP:**
  - All WAY_COUNT tag RAMs and all LINE_WORDS data RAMs are read at the request's set.
  - Hit: a way whose valid bit is set and whose stored tag equals the request tag. If several ways match (illegal), the lowest index wins.
  - Victim: the lowest-index invalid way; if every way is valid, the set's round-robin pointer.
  - No state changes.
- **FILL:**
  - Writes the tag and all line words into `req_way_i`.
  - Sets valid; clears dirty.
  - Advances the set's round-robin pointer to `req_way_i`+1 modulo WAY_COUNT.
- **WRITE:**
  - Byte-enabled write of one word, selected by the address word index, into `req_way_i`.
  - Sets dirty. Valid and tag are unchanged.
  - The hit check is the controller's job.
- **INVAL:** clears valid and dirty of (set, `req_way_i`).
- **FLUSH:**
  - Entered from IDLE when `flush_i` is high.
  - A set counter walks 0 to SET_COUNT−1, clearing all valid and dirty bits of one set per cycle.
  - After the last set the block returns to IDLE, pulses `flush_done_o`, and resets every round-robin pointer to 0.
  - `busy_o` = (state == FLUSH).
- **Response on non-LOOKUP ops:** `resp_valid_o` still pulses. `resp_hit_o`, `resp_victim_*` and `resp_line_o` reflect the pre-write contents of the addressed set.
- **Storage:** valid, dirty and round-robin state are flops. Tags and data are in `sp_ram_wrap` instances.

## Timing
- Every accepted request completes in one cycle: `resp_valid_o` goes high exactly one cycle after acceptance, for one cycle.
- Back-to-back requests are accepted every cycle while in IDLE.
- Write-then-read: a request accepted in cycle N+1 sees the effects of a FILL, WRITE or INVAL accepted in cycle N.
- Flush takes exactly SET_COUNT cycles in FLUSH. `flush_done_o` pulses in the first IDLE cycle. `req_ready_o` can be high in that same cycle.
- **Reset values:**
  - State is IDLE.
  - All valid, dirty and round-robin bits are 0.
  - `resp_valid_o`, `busy_o` and `flush_done_o` are 0.
  - Response data outputs are registered as 0.
- Reset during FLUSH aborts the flush; no `flush_done_o` is produced. RAM contents are undefined but unreachable, because all valid bits are 0.
- The set counter and round-robin arithmetic wrap modulo their power-of-two range.

## Configuration
- Macro: `CACHE_DIRTY_EN`.
- **Defined:** dirty flops exist per line. WRITE sets dirty. `resp_victim_dirty_o` reports the victim's dirty bit ANDed with its valid bit.
- **Undefined:** no dirty storage is built and `resp_victim_dirty_o` is constant 0. WRITE still updates data.

## Test plan
- **Reset then lookup:** LOOKUP 0x0000_0100 → `resp_valid_o`=1 after 1 cycle, `resp_hit_o`=0, `resp_way_o`=0.
- **Fill then lookup:** FILL addr 0x1234_5670, way 1, line {0x4,0x3,0x2,0x1}, then LOOKUP of the same address → hit=1, way=1, line={0x4,0x3,0x2,0x1}, victim_dirty=0.
- **Byte write:** WRITE 0x1234_5674, way 1, data 0xAABBCCDD, be=0b0011, then LOOKUP → word 1 = 0x0000CCDD. With `CACHE_DIRTY_EN`, a LOOKUP of a conflicting tag in the same set reports victim_dirty=1 once both ways are full.
- **Round-robin:** fill ways 0 and 1 of set 7, then LOOKUP a miss in set 7 → victim way 0. Fill way 0, LOOKUP the miss again → victim way 1.
- **Flush priority:** assert `flush_i` together with `req_valid_i` → `req_ready_o`=0, `busy_o` high for 64 cycles, `flush_done_o` pulses, and a subsequent LOOKUP of a previously filled line gives hit=0.
- **Reset mid-flush:** assert `reset` at flush cycle 20 → `busy_o`=0, no done pulse, and all lookups miss.
